// File: rtl/jtsdram_rdcheck_if.sv
// ---------------------------------------------------------------------------
// jtsdram_rdcheck_if
//   SDRAM read-port bundle between the read checker and the SDRAM controller.
//
//   addr  [AW-1:0]  read address, stable while rd is high
//   rd              read request, held until ack
//   ack             request accepted by the controller
//   dst             read data strobe, qualifies din
//   din   [15:0]    read data
//
//   master : the checker (drives addr/rd, receives ack/dst/din)
//   slave  : the controller or a memory model
// ---------------------------------------------------------------------------
interface jtsdram_rdcheck_if #(
    parameter int unsigned AW = 22
) ();
    logic [AW-1:0] addr;
    logic          rd;
    logic          ack;
    logic          dst;
    logic [15:0]   din;

    modport master (
        output addr, rd,
        input  ack, dst, din
    );

    modport slave (
        input  addr, rd,
        output ack, dst, din
    );
endinterface

// File: rtl/jtsdram_rdcheck.sv
// ---------------------------------------------------------------------------
// jtsdram_rdcheck
//   Read-side verifier for the SDRAM test core. Walks addresses 0..LAST,
//   issues one read per address, regenerates the pattern writer's 16-bit
//   Galois LFSR sequence and compares every returned word against it.
//
//   Parameters
//     AW    address width
//     LAST  final address checked in a pass (inclusive)
//     SEED  LFSR seed, must match the writer (0 is replaced by 1)
//     TOUT  cycles to wait for a data strobe after ack
//
//   Ports
//     clk       system clock
//     rst_n     asynchronous active-low reset
//     start     begin a pass (only looked at while idle)
//     clr       clear bad / err_cnt / err_addr (any state, beats a new error)
//     bus       SDRAM read port (master side)
//     busy      a pass is running
//     done      one-cycle pulse at the end of a pass
//     bad       sticky mismatch/timeout flag
//     err_cnt   errors seen, saturating at 255
//     err_addr  address of the first error since clr/reset
//     pass_cnt  completed passes, wraps
// ---------------------------------------------------------------------------
module jtsdram_rdcheck #(
    parameter int unsigned     AW   = 22,
    parameter logic [AW-1:0]   LAST = 22'h3FFFFF,
    parameter logic [15:0]     SEED = 16'hACE1,
    parameter logic [7:0]      TOUT = 8'd255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clr,
    jtsdram_rdcheck_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  bad,
    output logic [7:0]            err_cnt,
    output logic [AW-1:0]         err_addr,
    output logic [7:0]            pass_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        NEXT,
        DONE
    } state_t;

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t      state;
    logic [15:0] lfsr;
    logic [7:0]  tout;
    logic        chk_en;
    logic        tmo;
    logic        err_ev;

    // Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A strobe only counts while a read is outstanding: together with ack in
    // REQ, or in WAIT. Once the timeout has fired the FSM is in NEXT, so a
    // late strobe falls through to no compare.
    always_comb begin
        chk_en = 1'b0;
        tmo    = 1'b0;
        case (state)
            REQ:  chk_en = bus.ack & bus.dst;
            WAIT: begin
                chk_en = bus.dst;
                tmo    = !bus.dst && (tout == TOUT - 8'd1);
            end
            default: ;
        endcase
        err_ev = (chk_en && (bus.din != lfsr)) || tmo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.addr <= '0;
            bus.rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bad      <= 1'b0;
            err_cnt  <= 8'd0;
            err_addr <= '0;
            pass_cnt <= 8'd0;
            lfsr     <= SEED_EFF;
            tout     <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.addr <= '0;
                        lfsr     <= SEED_EFF;
                        busy     <= 1'b1;
                        bus.rd   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        bus.rd <= 1'b0;
                        tout   <= 8'd0;
                        // Data in the ack cycle was already checked above.
                        state  <= bus.dst ? NEXT : WAIT;
                    end
                end
                WAIT: begin
                    tout <= tout + 8'd1;
                    if (bus.dst || tmo)
                        state <= NEXT;
                end
                NEXT: begin
                    lfsr <= lfsr_next(lfsr);
                    if (bus.addr == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        bus.addr <= bus.addr + AW'(1);
                        bus.rd   <= 1'b1;
                        state    <= REQ;
                    end
                end
                DONE: begin
                    pass_cnt <= pass_cnt + 8'd1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // clr beats a simultaneous error; that error is dropped.
            if (clr) begin
                bad      <= 1'b0;
                err_cnt  <= 8'd0;
                err_addr <= '0;
            end else if (err_ev) begin
                bad     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                if (err_cnt == 8'd0)
                    err_addr <= bus.addr;
            end
        end
    end

endmodule

// File: tb/tb_jtsdram_rdcheck.sv
// ---------------------------------------------------------------------------
// tb_jtsdram_rdcheck
//   Directed bench for jtsdram_rdcheck with LAST = 3 and TOUT = 8. A small
//   memory model answers reads with the writer's words ACE1, E270, 7138, 389C
//   (addresses 0..3), optionally corrupted, dropped or strobed early.
// ---------------------------------------------------------------------------
module tb_jtsdram_rdcheck;

    localparam int unsigned AW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clr;
    logic          busy;
    logic          done;
    logic          bad;
    logic [7:0]    err_cnt;
    logic [AW-1:0] err_addr;
    logic [7:0]    pass_cnt;

    jtsdram_rdcheck_if #(.AW(AW)) bus ();

    jtsdram_rdcheck #(
        .AW   (AW),
        .LAST (22'd3),
        .SEED (16'hACE1),
        .TOUT (8'd8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clr      (clr),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .bad      (bad),
        .err_cnt  (err_cnt),
        .err_addr (err_addr),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int exp_pass = 0;
    int last_start_edge = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- memory model ----------------
    logic [15:0] exp_tab [4] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
    int       ack_dly   = 2;
    int       dst_dly   = 3;
    bit       same_cyc  = 1'b0;
    bit       stray_dst = 1'b0;
    logic [3:0] corrupt   = 4'b0000;
    logic [3:0] drop_mask = 4'b0000;
    int       stray_req  = 0;
    int       stray_done = 0;

    function automatic logic [15:0] rd_word(input logic [1:0] a);
        return exp_tab[a] ^ {15'd0, corrupt[a]};
    endfunction

    initial begin : mem_model
        logic [1:0] a;
        bus.ack = 1'b0;
        bus.dst = 1'b0;
        bus.din = 16'h0000;
        forever begin
            tick();
            if (bus.rd) begin
                a = bus.addr[1:0];
                if (stray_dst) begin
                    bus.dst = 1'b1;
                    bus.din = 16'h0000;
                end
                tick();
                bus.dst = 1'b0;
                repeat (ack_dly - 1) tick();
                bus.ack = 1'b1;
                if (same_cyc) begin
                    bus.dst = 1'b1;
                    bus.din = rd_word(a);
                end
                tick();
                bus.ack = 1'b0;
                bus.dst = 1'b0;
                if (!same_cyc && !drop_mask[a]) begin
                    repeat (dst_dly - 1) tick();
                    bus.dst = 1'b1;
                    bus.din = rd_word(a);
                    tick();
                    bus.dst = 1'b0;
                end
            end else if (stray_req != stray_done) begin
                bus.dst = 1'b1;
                bus.din = 16'h0000;
                tick();
                bus.dst = 1'b0;
                stray_done++;
            end
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    int            cyc = 0;
    int            n_hs = 0, n_rise = 0, n_dst = 0, n_done = 0;
    logic [AW-1:0] hs_addr   [2048];
    int            hs_edge   [2048];
    int            rise_edge [2048];
    int            dst_edge  [2048];
    int            bad_rise = 0;
    logic          rd_q = 1'b0;
    logic          bad_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rd && bus.ack && n_hs < 2048) begin
            hs_addr[n_hs] = bus.addr;
            hs_edge[n_hs] = cyc + 1;
            n_hs++;
        end
        if (bus.rd && !rd_q && n_rise < 2048) begin
            rise_edge[n_rise] = cyc;
            n_rise++;
        end
        if (bus.dst && n_dst < 2048) begin
            dst_edge[n_dst] = cyc + 1;
            n_dst++;
        end
        if (done) n_done++;
        if (bad && !bad_q) bad_rise = cyc;
        rd_q  = bus.rd;
        bad_q = bad;
    end

    // ---------------- helpers ----------------
    task automatic pulse_clr();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // clr_mode: 0 none, 1 asserted together with start, 2 held for the pass
    task automatic run_pass(input string tag, input bit mid_start, input int clr_mode);
        int d0;
        int n;
        d0 = n_done;
        n  = 0;
        tick();
        start = 1'b1;
        last_start_edge = cyc + 1;
        if (clr_mode != 0) clr = 1'b1;
        tick();
        start = 1'b0;
        if (clr_mode == 1) clr = 1'b0;
        if (mid_start) begin
            repeat (6) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        while (n_done == d0 && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(n_done != d0), 32'd1);
        repeat (3) tick();
        clr = 1'b0;
        if (n_done != d0) exp_pass++;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_addr"},     32'(bus.addr), 32'd0);
        check({tag, "_rd"},       32'(bus.rd),   32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_bad"},      32'(bad),      32'd0);
        check({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
        check({tag, "_err_addr"}, 32'(err_addr), 32'd0);
        check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int base, rbase, dbase, d0, n;

        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        repeat (3) tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Clean pass: four reads 0..3, one done, no errors.
        base = n_hs; rbase = n_rise; dbase = n_dst; d0 = n_done;
        run_pass("clean", 1'b0, 0);
        check("clean_reads", 32'(n_hs - base), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("clean_addr%0d", i), 32'(hs_addr[base + i]), 32'(i));
        check("clean_done_once", 32'(n_done - d0), 32'd1);
        check("clean_start_to_rd", 32'(rise_edge[rbase] - (last_start_edge - 1)), 32'd1);
        check("clean_dst_to_rd", 32'(rise_edge[rbase + 1] - (dst_edge[dbase] - 1)), 32'd2);
        check("clean_bad", 32'(bad), 32'd0);
        check("clean_err_cnt", 32'(err_cnt), 32'd0);
        check("clean_pass_cnt", 32'(pass_cnt), 32'd1);
        check("clean_busy", 32'(busy), 32'd0);

        // Address 2 returns 7139.
        corrupt = 4'b0100;
        base = n_hs;
        run_pass("corrupt", 1'b0, 0);
        check("corrupt_reads", 32'(n_hs - base), 32'd4);
        check("corrupt_last_addr", 32'(hs_addr[base + 3]), 32'd3);
        check("corrupt_bad", 32'(bad), 32'd1);
        check("corrupt_err_cnt", 32'(err_cnt), 32'd1);
        check("corrupt_err_addr", 32'(err_addr), 32'd2);
        check("corrupt_pass_cnt", 32'(pass_cnt), 32'(exp_pass));

        // Address 1 never strobes: error 8 cycles after its ack.
        pulse_clr();
        check("clr_bad", 32'(bad), 32'd0);
        corrupt   = 4'b0000;
        drop_mask = 4'b0010;
        base = n_hs;
        run_pass("tout", 1'b0, 0);
        drop_mask = 4'b0000;
        check("tout_reads", 32'(n_hs - base), 32'd4);
        check("tout_latency", 32'(bad_rise - hs_edge[base + 1]), 32'd8);
        check("tout_addr2", 32'(hs_addr[base + 2]), 32'd2);
        check("tout_addr3", 32'(hs_addr[base + 3]), 32'd3);
        check("tout_err_cnt", 32'(err_cnt), 32'd1);
        check("tout_err_addr", 32'(err_addr), 32'd1);

        // Stray strobe while idle is not compared.
        pulse_clr();
        stray_req++;
        repeat (5) tick();
        check("idle_dst_bad", 32'(bad), 32'd0);
        check("idle_dst_err_cnt", 32'(err_cnt), 32'd0);

        // Strobe before ack and start mid-pass are both ignored.
        stray_dst = 1'b1;
        base = n_hs; d0 = n_done;
        run_pass("stray", 1'b1, 0);
        stray_dst = 1'b0;
        check("stray_reads", 32'(n_hs - base), 32'd4);
        check("stray_addr3", 32'(hs_addr[base + 3]), 32'd3);
        check("stray_done_once", 32'(n_done - d0), 32'd1);
        check("stray_bad", 32'(bad), 32'd0);
        check("stray_pass_cnt", 32'(pass_cnt), 32'(exp_pass));

        // ack and dst together: checked in that cycle, no WAIT.
        same_cyc = 1'b1;
        ack_dly  = 1;
        corrupt  = 4'b0010;
        base = n_hs; rbase = n_rise;
        run_pass("same", 1'b0, 0);
        check("same_reads", 32'(n_hs - base), 32'd4);
        check("same_ack_to_rd", 32'(rise_edge[rbase + 1] - (hs_edge[base] - 1)), 32'd2);
        check("same_err_cnt", 32'(err_cnt), 32'd1);
        check("same_err_addr", 32'(err_addr), 32'd1);

        // 300 errors over 75 passes: saturation at 255.
        pulse_clr();
        corrupt = 4'b1111;
        for (int p = 0; p < 63; p++) run_pass("sat", 1'b0, 0);
        check("sat_252", 32'(err_cnt), 32'd252);
        run_pass("sat", 1'b0, 0);
        check("sat_255", 32'(err_cnt), 32'd255);
        for (int p = 0; p < 11; p++) run_pass("sat", 1'b0, 0);
        check("sat_hold", 32'(err_cnt), 32'd255);
        check("sat_err_addr", 32'(err_addr), 32'd0);
        check("sat_bad", 32'(bad), 32'd1);
        check("sat_pass_cnt", 32'(pass_cnt), 32'(exp_pass & 8'hFF));
        pulse_clr();
        check("satclr_bad", 32'(bad), 32'd0);
        check("satclr_err_cnt", 32'(err_cnt), 32'd0);
        check("satclr_err_addr", 32'(err_addr), 32'd0);

        // New errors, then start and clr in the same cycle.
        run_pass("refill", 1'b0, 0);
        check("refill_err_cnt", 32'(err_cnt), 32'd4);
        corrupt = 4'b1000;
        run_pass("startclr", 1'b0, 1);
        check("startclr_err_cnt", 32'(err_cnt), 32'd1);
        check("startclr_err_addr", 32'(err_addr), 32'd3);

        // clr held through a fully corrupt pass wins over every error.
        corrupt = 4'b1111;
        run_pass("clrhold", 1'b0, 2);
        check("clrhold_bad", 32'(bad), 32'd0);
        check("clrhold_err_cnt", 32'(err_cnt), 32'd0);
        corrupt = 4'b0010;
        run_pass("after_clr", 1'b0, 0);
        check("after_clr_err_addr", 32'(err_addr), 32'd1);
        check("after_clr_pass_cnt", 32'(pass_cnt), 32'(exp_pass & 8'hFF));

        // Asynchronous reset while waiting for address 1 data.
        same_cyc = 1'b0;
        ack_dly  = 2;
        dst_dly  = 3;
        corrupt  = 4'b0001;
        base = n_hs; d0 = n_done; n = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n_hs < base + 2 && n < 200) begin
            tick();
            n++;
        end
        check("rst_reach_wait", 32'(n_hs - base), 32'd2);
        tick();
        tick();
        check("rst_pre_bad", 32'(bad), 32'd1);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("rst_no_done", 32'(n_done - d0), 32'd0);
        check("rst_busy_after", 32'(busy), 32'd0);
        exp_pass = 0;
        corrupt  = 4'b0000;
        base = n_hs;
        run_pass("restart", 1'b0, 0);
        check("restart_addr0", 32'(hs_addr[base]), 32'd0);
        check("restart_reads", 32'(n_hs - base), 32'd4);
        check("restart_bad", 32'(bad), 32'd0);
        check("restart_err_cnt", 32'(err_cnt), 32'd0);
        check("restart_pass_cnt", 32'(pass_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
